// File: rtl/keypad_emulator.sv
// 4x4 matrix keypad responder: pulls the matching active-low column while a
// commanded key is held, with press, bounce and release timing.
module keypad_emulator #(
  parameter int PRESS_CYCLES   = 1500000,
  parameter int RELEASE_CYCLES = 1000000,
  parameter int BOUNCE_CYCLES  = 50000,
  parameter int BOUNCE_TOGGLE  = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] column,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  output logic       press_done
);

  localparam int MAX_PR   = (PRESS_CYCLES > RELEASE_CYCLES) ? PRESS_CYCLES : RELEASE_CYCLES;
  localparam int MAX_BT   = (BOUNCE_CYCLES > BOUNCE_TOGGLE) ? BOUNCE_CYCLES : BOUNCE_TOGGLE;
  localparam int MAX_P    = (MAX_PR > MAX_BT) ? MAX_PR : MAX_BT;
  localparam int CW       = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] PRESS_LAST   = CW'(PRESS_CYCLES - 1);
  localparam logic [CW-1:0] RELEASE_LAST = CW'(RELEASE_CYCLES - 1);
  localparam logic [CW-1:0] BOUNCE_LAST  = CW'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
  localparam logic [CW-1:0] TOGGLE_LAST  = CW'(BOUNCE_TOGGLE - 1);

  typedef enum logic [2:0] {IDLE, BOUNCE_IN, PRESSED, BOUNCE_OUT, GAP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] tcnt;
  logic          phase;
  logic [3:0]    key_lat;
  logic [3:0]    key_row;
  logic [3:0]    key_col;
  logic          contact;
  logic          row_hit;
  logic          in_bounce;

  always_comb begin
    key_row = 4'b1111;
    key_col = 4'b1111;
    case (key_lat)
      4'h1, 4'h4, 4'h7, 4'hE: key_row = 4'b0111;
      4'h2, 4'h5, 4'h8, 4'h0: key_row = 4'b1011;
      4'h3, 4'h6, 4'h9, 4'hF: key_row = 4'b1101;
      default:                key_row = 4'b1110;
    endcase
    case (key_lat)
      4'h1, 4'h2, 4'h3, 4'hA: key_col = 4'b0111;
      4'h4, 4'h5, 4'h6, 4'hB: key_col = 4'b1011;
      4'h7, 4'h8, 4'h9, 4'hC: key_col = 4'b1101;
      default:                key_col = 4'b1110;
    endcase
  end

  assign in_bounce = (state == BOUNCE_IN) || (state == BOUNCE_OUT);
  assign contact   = (state == PRESSED) || (in_bounce && phase);
  // Only the latched key's row bit matters; other rows are don't-care.
  assign row_hit   = |(~row & ~key_row);
  assign key_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      tcnt       <= '0;
      phase      <= 1'b0;
      key_lat    <= '0;
      column     <= '1;
      press_done <= 1'b0;
    end else begin
      press_done <= 1'b0;
      column     <= (contact && row_hit) ? key_col : 4'b1111;

      if (in_bounce) begin
        if (tcnt == TOGGLE_LAST) begin
          phase <= ~phase;
          tcnt  <= '0;
        end else begin
          tcnt <= tcnt + CW'(1);
        end
      end

      case (state)
        IDLE: begin
          if (key_valid) begin
            key_lat <= key_code;
            cnt     <= '0;
            tcnt    <= '0;
            phase   <= 1'b1;
            state   <= (BOUNCE_CYCLES == 0) ? PRESSED : BOUNCE_IN;
          end
        end
        BOUNCE_IN: begin
          if (cnt == BOUNCE_LAST) begin
            cnt   <= '0;
            state <= PRESSED;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PRESSED: begin
          if (cnt == PRESS_LAST) begin
            cnt   <= '0;
            tcnt  <= '0;
            phase <= 1'b1;
            state <= (BOUNCE_CYCLES == 0) ? GAP : BOUNCE_OUT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        BOUNCE_OUT: begin
          if (cnt == BOUNCE_LAST) begin
            cnt   <= '0;
            state <= GAP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        GAP: begin
          if (cnt == RELEASE_LAST) begin
            cnt        <= '0;
            state      <= IDLE;
            press_done <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Scoreboard bench for keypad_emulator: stimulus queues expected per-cycle
// outputs, a negedge monitor pops and compares them.
module tb_keypad_emulator;

  localparam int PC = 20;
  localparam int RC = 10;

  logic       clk = 1'b0;
  logic       rst        [2];
  logic [3:0] row        [2];
  logic [3:0] column     [2];
  logic [3:0] key_code   [2];
  logic       key_valid  [2];
  logic       key_ready  [2];
  logic       press_done [2];

  always #5 clk = ~clk;

  keypad_emulator #(.PRESS_CYCLES(PC), .RELEASE_CYCLES(RC), .BOUNCE_CYCLES(0), .BOUNCE_TOGGLE(1)) u_nb (
    .clk(clk), .rst(rst[0]), .row(row[0]), .column(column[0]), .key_code(key_code[0]),
    .key_valid(key_valid[0]), .key_ready(key_ready[0]), .press_done(press_done[0]));

  keypad_emulator #(.PRESS_CYCLES(PC), .RELEASE_CYCLES(RC), .BOUNCE_CYCLES(12), .BOUNCE_TOGGLE(3)) u_b (
    .clk(clk), .rst(rst[1]), .row(row[1]), .column(column[1]), .key_code(key_code[1]),
    .key_valid(key_valid[1]), .key_ready(key_ready[1]), .press_done(press_done[1]));

  typedef struct packed {
    logic [3:0] col;
    logic       rdy;
    logic       done;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic expect_cycle(input int d, input logic [3:0] col, input logic rdy, input logic done);
    exp_t e;
    e.col  = col;
    e.rdy  = rdy;
    e.done = done;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic check(input int d, input exp_t e);
    n_checks++;
    if (column[d] !== e.col) begin
      n_fail++;
      $display("FAIL dut%0d column @%0t: got %b expected %b", d, $time, column[d], e.col);
    end
    n_checks++;
    if (key_ready[d] !== e.rdy) begin
      n_fail++;
      $display("FAIL dut%0d key_ready @%0t: got %b expected %b", d, $time, key_ready[d], e.rdy);
    end
    n_checks++;
    if (press_done[d] !== e.done) begin
      n_fail++;
      $display("FAIL dut%0d press_done @%0t: got %b expected %b", d, $time, press_done[d], e.done);
    end
  endtask

  always @(negedge clk) begin
    if (q0.size() != 0) check(0, q0.pop_front());
    if (q1.size() != 0) check(1, q1.pop_front());
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Contact state during the idx-th cycle after accept (idx 0 = first cycle).
  function automatic bit closed(input int idx, input int bc, input int bt);
    if (idx < 0) return 1'b0;
    if (bc == 0) return idx < PC;
    if (idx < bc) return ((idx / bt) % 2) == 0;
    if (idx < bc + PC) return 1'b1;
    if (idx < 2 * bc + PC) return (((idx - bc - PC) / bt) % 2) == 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] scan_row(input int k);
    case ((k / 4) % 4)
      0:       return 4'b0111;
      1:       return 4'b1011;
      2:       return 4'b1101;
      default: return 4'b1110;
    endcase
  endfunction

  // mode 0 holds row at rowc, mode 1 scans rows every 4 cycles.
  task automatic press(input int d, input logic [3:0] code, input logic [3:0] krow,
                       input logic [3:0] kcol, input int mode, input logic [3:0] rowc,
                       input int bc, input int bt, input bit spam, input int abort_at);
    int total;
    logic [3:0] r;
    total = PC + RC + 2 * bc;
    for (int k = 0; k <= total; k++) begin
      if (k == abort_at) begin
        rst[d]       = 1'b1;
        key_valid[d] = 1'b0;
        expect_cycle(d, 4'b1111, 1'b0, 1'b0);
        step();
        rst[d] = 1'b0;
        return;
      end
      r            = (mode == 0) ? rowc : scan_row(k);
      row[d]       = r;
      rst[d]       = 1'b0;
      key_valid[d] = (k == 0) || (spam && k >= 5);
      key_code[d]  = (k == 0) ? code : 4'h9;
      expect_cycle(d, (closed(k - 1, bc, bt) && ((~r & ~krow) != 4'b0000)) ? kcol : 4'b1111,
                   k == total, k == total);
      step();
    end
    key_valid[d] = 1'b0;
  endtask

  task automatic idle(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      key_valid[d] = 1'b0;
      rst[d]       = 1'b0;
      expect_cycle(d, 4'b1111, 1'b1, 1'b0);
      step();
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d]       = 1'b1;
      row[d]       = 4'b1011;
      key_code[d]  = 4'h5;
      key_valid[d] = 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      expect_cycle(0, 4'b1111, 1'b0, 1'b0);
      expect_cycle(1, 4'b1111, 1'b0, 1'b0);
      step();
    end
    for (int d = 0; d < 2; d++) begin
      rst[d]       = 1'b0;
      key_valid[d] = 1'b0;
    end
    expect_cycle(0, 4'b1111, 1'b1, 1'b0);
    expect_cycle(1, 4'b1111, 1'b1, 1'b0);
    step();

    press(0, 4'h5, 4'b1011, 4'b1011, 0, 4'b1011, 0, 1, 1'b0, -1);
    idle(0, 2);
    press(0, 4'h0, 4'b1011, 4'b1110, 1, 4'b1111, 0, 1, 1'b0, -1);
    idle(0, 2);
    press(0, 4'h5, 4'b1011, 4'b1011, 0, 4'b1011, 0, 1, 1'b1, -1);
    press(0, 4'h9, 4'b1101, 4'b1101, 0, 4'b1101, 0, 1, 1'b0, -1);
    idle(0, 2);
    press(0, 4'h1, 4'b0111, 4'b0111, 0, 4'b0111, 0, 1, 1'b0, 8);
    press(0, 4'h1, 4'b0111, 4'b0111, 0, 4'b0111, 0, 1, 1'b0, -1);
    idle(0, 2);

    idle(1, 2);
    press(1, 4'hD, 4'b1110, 4'b1110, 0, 4'b1110, 12, 3, 1'b0, -1);
    idle(1, 3);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
